// File: rtl/arb_pkg.sv
// Shared types and default sizing for the 2:1 bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int ARB_ADDR_W  = 8;
  localparam int ARB_TIMEOUT = 15;

endpackage

// File: rtl/mux2_vec.sv
// Vector 2:1 multiplexer: y = b when sel is high, else a.
module mux2_vec #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin arbiter for two requesters sharing one memory port.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_2to1
  import arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              done0,
  output logic              done1,
  output logic              err
);

  arb_state_e state, state_nxt;
  logic       last, last_nxt;
  logic       timeout_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // A grant ends only on mem_ack or watchdog expiry; req is not looked at.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (req0 && req1)
          state_nxt = last ? GNT0 : GNT1;
        else if (req0)
          state_nxt = GNT0;
        else if (req1)
          state_nxt = GNT1;
      end
      GNT0: begin
        if (mem_ack) begin
          last_nxt  = 1'b0;
          state_nxt = req1 ? GNT1 : IDLE;
        end else if (timeout_hit) begin
          last_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (mem_ack) begin
          last_nxt  = 1'b1;
          state_nxt = req0 ? GNT0 : IDLE;
        end else if (timeout_hit) begin
          last_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             err_q;

  // Counter restarts on every grant entry, so a back-to-back handover gets a fresh budget.
  assign timeout_hit = (state != IDLE) && !mem_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wait_cnt_nxt = '0;
    if ((state != IDLE) && (state_nxt == state))
      wait_cnt_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      err_q    <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
  assign err            = 1'b0;
`endif

  assign gnt0    = (state == GNT0);
  assign gnt1    = (state == GNT1);
  assign sel     = (state == GNT1);
  assign mem_req = gnt0 | gnt1;
  assign done0   = gnt0 & mem_ack;
  assign done1   = gnt1 & mem_ack;

  mux2_vec #(
    .W(ADDR_W)
  ) u_addr_mux (
    .sel(sel),
    .a  (addr0),
    .b  (addr1),
    .y  (mem_addr)
  );

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Scenario bench for bus_arbiter_2to1; expected grants are queued at stimulus time and popped on grant.
module tb_bus_arbiter_2to1;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1, sel, mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              done0, done1, err;

  typedef struct {
    logic              g0;
    logic              g1;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  bus_arbiter_2to1 #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .addr0   (addr0),
    .addr1   (addr1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .done0   (done0),
    .done1   (done1),
    .err     (err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; mem_ack = 1'b0;
    addr0 = 8'hA5; addr1 = 8'h5A;
    repeat (2) @(negedge clk);
    outs = {gnt0, gnt1, sel, mem_req, done0, done1, err};
    total_cnt++;
    if (outs !== 7'b0) $display("FAIL reset_outs: got %b want 0000000", outs);
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 8'hA5) $display("FAIL reset_mem_addr: got %h want a5", mem_addr);
    else pass_cnt++;
    req0 = 1'b0; req1 = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    outs = {gnt0, gnt1, sel, mem_req, done0, done1, err};
    total_cnt++;
    if (outs !== 7'b0) $display("FAIL reset_idle_after: got %b want 0000000", outs);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    addr0 = 8'h12; addr1 = 8'h99;
    req0 = 1'b1;
    exp_q.push_back('{g0: 1'b1, g1: 1'b0, addr: 8'h12});
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if ({gnt0, gnt1, sel, mem_req} !== {e.g0, e.g1, e.g1, 1'b1})
      $display("FAIL single_grant: got %b want %b", {gnt0, gnt1, sel, mem_req}, {e.g0, e.g1, e.g1, 1'b1});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== e.addr) $display("FAIL single_addr: got %h want %h", mem_addr, e.addr);
    else pass_cnt++;
    mem_ack = 1'b1;
    #1;
    total_cnt++;
    if ({done0, done1} !== 2'b10) $display("FAIL single_done: got %b want 10", {done0, done1});
    else pass_cnt++;
    @(negedge clk);
    mem_ack = 1'b0; req0 = 1'b0;
    total_cnt++;
    if ({gnt0, gnt1, mem_req} !== 3'b000) $display("FAIL single_idle: got %b want 000", {gnt0, gnt1, mem_req});
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    addr0 = 8'h21; addr1 = 8'h43;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back('{g0: 1'b1, g1: 1'b0, addr: 8'h21});
      else            exp_q.push_back('{g0: 1'b0, g1: 1'b1, addr: 8'h43});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      e = exp_q.pop_front();
      total_cnt++;
      if ({gnt0, gnt1, sel, mem_req} !== {e.g0, e.g1, e.g1, 1'b1})
        $display("FAIL rr_grant%0d: got %b want %b", i, {gnt0, gnt1, sel, mem_req}, {e.g0, e.g1, e.g1, 1'b1});
      else pass_cnt++;
      total_cnt++;
      if (mem_addr !== e.addr) $display("FAIL rr_addr%0d: got %h want %h", i, mem_addr, e.addr);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({gnt0, gnt1, done0, done1} !== {e.g0, e.g1, 2'b00})
        $display("FAIL rr_hold%0d: got %b want %b", i, {gnt0, gnt1, done0, done1}, {e.g0, e.g1, 2'b00});
      else pass_cnt++;
      @(negedge clk);
      mem_ack = 1'b1;
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      #1;
      total_cnt++;
      if ({done0, done1} !== {e.g0, e.g1})
        $display("FAIL rr_done%0d: got %b want %b", i, {done0, done1}, {e.g0, e.g1});
      else pass_cnt++;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    total_cnt++;
    if (mem_req !== 1'b0) $display("FAIL rr_final_idle: got %b want 0", mem_req);
    else pass_cnt++;
  endtask

  task automatic test_ack_idle();
    do_reset();
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    total_cnt++;
    if ({done0, done1} !== 2'b00) $display("FAIL idle_ack_done: got %b want 00", {done0, done1});
    else pass_cnt++;
    @(negedge clk);
    mem_ack = 1'b0;
    total_cnt++;
    if ({gnt0, gnt1, mem_req} !== 3'b000) $display("FAIL idle_ack_state: got %b want 000", {gnt0, gnt1, mem_req});
    else pass_cnt++;
    // tie-break must still favour requester 0 after the stray ack
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back('{g0: 1'b1, g1: 1'b0, addr: addr0});
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if ({gnt0, gnt1} !== {e.g0, e.g1}) $display("FAIL idle_ack_tie: got %b want %b", {gnt0, gnt1}, {e.g0, e.g1});
    else pass_cnt++;
    mem_ack = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr0 = 8'h30; addr1 = 8'hC7;
    req1 = 1'b1;
    exp_q.push_back('{g0: 1'b0, g1: 1'b1, addr: 8'hC7});
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if ({gnt0, gnt1, sel, mem_addr} !== {e.g0, e.g1, e.g1, e.addr})
      $display("FAIL mid_grant1: got %b/%h want %b/%h", {gnt0, gnt1, sel}, mem_addr, {e.g0, e.g1, e.g1}, e.addr);
    else pass_cnt++;
    reset_n = 1'b0;
    req0 = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({gnt0, gnt1, sel, mem_req, done0, done1, err} !== 7'b0)
      $display("FAIL mid_reset_outs: got %b want 0000000", {gnt0, gnt1, sel, mem_req, done0, done1, err});
    else pass_cnt++;
    reset_n = 1'b1;
    exp_q.push_back('{g0: 1'b1, g1: 1'b0, addr: 8'h30});
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if ({gnt0, gnt1, mem_addr} !== {e.g0, e.g1, e.addr})
      $display("FAIL mid_first_after: got %b/%h want %b/%h", {gnt0, gnt1}, mem_addr, {e.g0, e.g1}, e.addr);
    else pass_cnt++;
    mem_ack = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int held;
    do_reset();
    addr0 = 8'h0F; addr1 = 8'hF0;
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back('{g0: 1'b0, g1: 1'b1, addr: 8'hF0});
    held = 0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (!gnt0 || err) break;
      held++;
      @(negedge clk);
    end
    total_cnt++;
    if (held !== 15) $display("FAIL to_gnt_cycles: got %0d want 15", held);
    else pass_cnt++;
    total_cnt++;
    if ({err, gnt0, gnt1, done0, done1} !== 5'b10000)
      $display("FAIL to_err_pulse: got %b want 10000", {err, gnt0, gnt1, done0, done1});
    else pass_cnt++;
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if ({err, gnt0, gnt1, mem_addr} !== {1'b0, e.g0, e.g1, e.addr})
      $display("FAIL to_next_grant: got %b/%h want %b/%h", {err, gnt0, gnt1}, mem_addr, {1'b0, e.g0, e.g1}, e.addr);
    else pass_cnt++;
    mem_ack = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask
`else
  task automatic test_hold();
    int held;
    int errs;
    do_reset();
    addr0 = 8'h0F; addr1 = 8'hF0;
    req0 = 1'b1;
    held = 0;
    errs = 0;
    @(negedge clk);
    for (int i = 0; i < 110; i++) begin
      if (i == 3) req1 = 1'b1;
      if (i == 5) req0 = 1'b0;
      if (gnt0 && !gnt1) held++;
      if (err) errs++;
      @(negedge clk);
    end
    total_cnt++;
    if (held !== 110) $display("FAIL hold_gnt_cycles: got %0d want 110", held);
    else pass_cnt++;
    total_cnt++;
    if (errs !== 0) $display("FAIL hold_err_cycles: got %0d want 0", errs);
    else pass_cnt++;
    mem_ack = 1'b1;
    #1;
    total_cnt++;
    if (done0 !== 1'b1) $display("FAIL hold_late_done: got %b want 1", done0);
    else pass_cnt++;
    req1 = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
    addr0 = '0; addr1 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_ack_idle();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2to1.md
BUS_ARBITER_2TO1 -- requirements
Module: bus_arbiter_2to1

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of each address bus.
REQ-002 SHALL have parameter TIMEOUT, default 15, max wait cycles for mem_ack (used only with ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports req0, req1  input  1 each  requester access request, held until done.
REQ-006 SHALL have ports addr0, addr1  input  ADDR_W each  requester address, stable while req high.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  registered grant, one-hot or zero.
REQ-008 SHALL have port sel  output  1  select for shared 2:1 mux, 0 = requester 0, 1 = requester 1.
REQ-009 SHALL have port mem_req  output  1  request to shared memory port.
REQ-010 SHALL have port mem_addr  output  ADDR_W  muxed address, addr1 when sel=1, else addr0.
REQ-011 SHALL have port mem_ack  input  1  single-cycle completion from memory.
REQ-012 SHALL have ports done0, done1  output  1 each  completion pulse to requester.
REQ-013 SHALL have port err  output  1  one-cycle timeout abort pulse.

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-015 IDLE: req0 only -> GNT0; req1 only -> GNT1; both -> state not equal to last-served pointer (round robin); none -> IDLE.
REQ-016 Grant latency SHALL be one cycle: gntX high in the cycle after reqX is sampled in IDLE.
REQ-017 gnt0 = (state==GNT0), gnt1 = (state==GNT1); sel = (state==GNT1); mem_req = gnt0|gnt1.
REQ-018 mem_addr SHALL be combinational from sel, addr0, addr1, in every state.
REQ-019 doneX SHALL be combinational gntX & mem_ack; requester drops reqX at the edge sampling doneX.
REQ-020 On mem_ack in GNTx: last pointer <- x; next state = grant of the other requester if its req is high, else IDLE.
REQ-021 Back-to-back alternation SHALL need no IDLE cycle; same requester re-issuing SHALL pass through IDLE.
REQ-022 mem_ack in IDLE SHALL be ignored: no done, no state change.
REQ-023 Requester dropping req while granted SHALL NOT release the grant; only mem_ack (or timeout) ends it.

Reset
REQ-024 With reset_n low at a rising edge: state IDLE, last pointer = 1 (req0 wins first tie), wait counter 0, err 0.
REQ-025 Outputs after reset: gnt0=gnt1=0, sel=0, mem_req=0, done0=done1=0, err=0.
REQ-026 Reset mid-transaction SHALL abort silently: no done, no err pulse.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: counter clears on grant entry, increments each GNTx cycle without mem_ack; reaching TIMEOUT SHALL force IDLE, pulse err one cycle, update last pointer, no done.
REQ-028 Macro ARB_TIMEOUT_EN undefined: no counter, grant held indefinitely, err tied 0.

Structure
REQ-029 Shared package arb_pkg SHALL hold the FSM state type and default ADDR_W/TIMEOUT constants.
REQ-030 Address selection SHALL be a sub-module mux2_vec (ADDR_W-wide 2:1 mux, sel input); FSM and counter in bus_arbiter_2to1.

Verification
REQ-031 Reset then req0=1, addr0=8'h12: gnt0=1 next cycle, mem_addr=8'h12, sel=0; mem_ack -> done0=1 same cycle, IDLE next.
REQ-032 req0=req1=1 from reset: grant order GNT0, GNT1, GNT0 with mem_ack each third cycle; no IDLE between alternations.
REQ-033 mem_ack pulsed in IDLE with no req: done0=done1=0, state stays IDLE.
REQ-034 reset_n low while gnt1=1: all outputs 0 next edge, no done1/err; req0 and req1 both high afterward -> GNT0 first.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT=15, mem_ack never: err=1 for one cycle 15 cycles after grant, gnt cleared, other requester served next.
REQ-036 ARB_TIMEOUT_EN undefined: same stimulus keeps gnt high 100+ cycles, err stays 0.
